// File: rtl/cpu_debug_pkg.sv
// Shared types and constants for the CPU debug register dump path.
// Optional header byte per register is enabled by defining REG_DUMP_HEADER_EN.
package cpu_debug_pkg;

  typedef enum logic [1:0] {IDLE, READ, SEND, DONE} dump_state_t;

  localparam int BYTES_PER_REG = 4;

`ifdef REG_DUMP_HEADER_EN
  localparam int HEADER_BYTE_COUNT = 1;
`else
  localparam int HEADER_BYTE_COUNT = 0;
`endif

  localparam int BC_WIDTH = 3;
  localparam logic [BC_WIDTH-1:0] BC_LAST = BC_WIDTH'(BYTES_PER_REG + HEADER_BYTE_COUNT - 1);

endpackage

// File: rtl/dump_byte_mux.sv
// Selects the outgoing byte from {header, shadow} by byte counter, MSB first.
// With REG_DUMP_HEADER_EN the header occupies bc=0, otherwise it is never selected.
module dump_byte_mux
  import cpu_debug_pkg::*;
(
  input  logic [31:0]         shadow,
  input  logic [7:0]          header,
  input  logic [BC_WIDTH-1:0] bc,
  output logic [7:0]          byte_data
);

  logic [39:0] frame;
  logic [5:0]  lsb;

  // bc counts from the first emitted byte; without a header the frame starts one byte lower
  always_comb begin
    frame     = {header, shadow};
    lsb       = 6'(8 * (BYTES_PER_REG - 1 + HEADER_BYTE_COUNT - int'(bc)));
    byte_data = frame[lsb +: 8];
  end

endmodule

// File: rtl/reg_dump_reader.sv
// Walks the register file debug read port and streams each register as bytes
// over a valid/ready interface. REG_DUMP_HEADER_EN adds an index byte per register.
module reg_dump_reader
  import cpu_debug_pkg::*;
#(
  parameter int REG_COUNT  = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  iCpuClock,
  input  logic                  iCpuReset,
  input  logic                  iDumpStart,
  input  logic                  iDumpAbort,
  output logic [ADDR_WIDTH-1:0] oRegAddr,
  input  logic [DATA_WIDTH-1:0] iRegData,
  output logic                  oByteValid,
  input  logic                  iByteReady,
  output logic [7:0]            oByteData,
  output logic                  oBusy,
  output logic                  oDumpDone
);

  dump_state_t           state;
  dump_state_t           state_nxt;
  logic [ADDR_WIDTH-1:0] idx;
  logic [BC_WIDTH-1:0]   bc;
  logic [DATA_WIDTH-1:0] shadow;
  logic [7:0]            mux_byte;
  logic                  xfer;
  logic                  bc_last;
  logic                  idx_last;

  assign xfer     = (state == SEND) && iByteReady;
  assign bc_last  = (bc == BC_LAST);
  assign idx_last = (idx == ADDR_WIDTH'(REG_COUNT - 1));

  always_ff @(posedge iCpuClock or negedge iCpuReset) begin
    if (!iCpuReset) state <= IDLE;
    else            state <= state_nxt;
  end

  // Abort wins over any transfer in the same cycle
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (iDumpStart) state_nxt = READ;
      READ: state_nxt = iDumpAbort ? IDLE : SEND;
      SEND: begin
        if (iDumpAbort)           state_nxt = IDLE;
        else if (xfer && bc_last) state_nxt = idx_last ? DONE : READ;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge iCpuClock or negedge iCpuReset) begin
    if (!iCpuReset) begin
      idx    <= '0;
      bc     <= '0;
      shadow <= '0;
    end else begin
      case (state)
        IDLE: if (iDumpStart) idx <= '0;
        READ: if (!iDumpAbort) begin
          shadow <= iRegData;
          bc     <= '0;
        end
        SEND: if (!iDumpAbort && xfer) begin
          if (!bc_last)      bc  <= bc + 1'b1;
          else if (!idx_last) idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  dump_byte_mux u_mux (
    .shadow    (shadow[31:0]),
    .header    (8'(idx)),
    .bc        (bc),
    .byte_data (mux_byte)
  );

  always_comb begin
    oRegAddr   = idx;
    oByteValid = (state == SEND);
    oByteData  = (state == SEND) ? mux_byte : 8'h00;
    oBusy      = (state != IDLE);
    oDumpDone  = (state == DONE);
  end

endmodule

// File: tb/tb_reg_dump_reader.sv
// Scoreboard bench for reg_dump_reader: expected bytes are queued at start and
// popped on every valid/ready transfer. Honours REG_DUMP_HEADER_EN.
module tb_reg_dump_reader;

`ifdef REG_DUMP_HEADER_EN
  localparam int BPR      = 5;
  localparam int DONE_CYC = 193;
`else
  localparam int BPR      = 4;
  localparam int DONE_CYC = 161;
`endif
  localparam int NBYTES = 32 * BPR;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [4:0]  reg_addr;
  logic [31:0] reg_data;
  logic        byte_valid;
  logic        byte_ready;
  logic [7:0]  byte_data;
  logic        busy;
  logic        dump_done;

  logic [31:0] regs [32];
  logic [7:0]  exp_q [$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int base = 0;
  int bytes_rx = 0;
  int done_cnt = 0;
  int done_cycle = -1;
  int idle_cycle = -1;
  bit tracking = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  assign reg_data = regs[reg_addr];

  reg_dump_reader dut (
    .iCpuClock  (clk),
    .iCpuReset  (rst_n),
    .iDumpStart (start),
    .iDumpAbort (abort),
    .oRegAddr   (reg_addr),
    .iRegData   (reg_data),
    .oByteValid (byte_valid),
    .iByteReady (byte_ready),
    .oByteData  (byte_data),
    .oBusy      (busy),
    .oDumpDone  (dump_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc - base);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int r, input int k);
    logic [31:0] w;
    w = regs[r];
`ifdef REG_DUMP_HEADER_EN
    if (k == 0) return {3'b000, 5'(r)};
    return w[31 - 8*(k-1) -: 8];
`else
    return w[31 - 8*k -: 8];
`endif
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (byte_valid && byte_ready) begin
        bytes_rx++;
        if (exp_q.size() == 0) chk("extra_byte", 32'(byte_data), 32'hxx);
        else chk("byte", 32'(byte_data), 32'(exp_q.pop_front()));
      end
      if (dump_done) begin
        done_cnt++;
        done_cycle = cyc - base;
      end
      if (tracking && !busy && (cyc - base) >= 1) begin
        idle_cycle = cyc - base;
        tracking   = 0;
      end
    end
  end

  task automatic start_dump();
    exp_q.delete();
    for (int r = 0; r < 32; r++)
      for (int k = 0; k < BPR; k++) exp_q.push_back(exp_byte(r, k));
    bytes_rx   = 0;
    done_cnt   = 0;
    done_cycle = -1;
    idle_cycle = -1;
    base       = cyc;
    tracking   = 1;
    start      = 1'b1;
    @(posedge clk); #1;
    start      = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (done_cnt == 0) chk("done_timeout", 0, 1);
  endtask

  task automatic wait_bytes(input int cnt, input int budget);
    int n = 0;
    while (!(bytes_rx == cnt && byte_valid) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= budget) chk("byte_wait_timeout", 0, 1);
  endtask

  task automatic wait_cycle(input int c);
    int n = 0;
    while ((cyc - base) < c && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'hA500_0000 + 32'(i);
    rst_n      = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    byte_ready = 1'b1;
    #12;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(byte_valid), 0);
    chk("rst_data", 32'(byte_data), 0);
    chk("rst_done", 32'(dump_done), 0);
    chk("rst_addr", 32'(reg_addr), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // full dump, sink always ready
    start_dump();
    chk("busy_c1", 32'(busy), 1);
    wait_done(400);
    repeat (2) @(posedge clk);
    #1;
    chk("full_bytes", bytes_rx, NBYTES);
    chk("full_done_cyc", done_cycle, DONE_CYC);
    chk("full_idle_cyc", idle_cycle, DONE_CYC + 1);
    chk("full_done_cnt", done_cnt, 1);
    chk("full_q_empty", exp_q.size(), 0);

    // backpressure on the 2nd byte of reg 5
    start_dump();
    wait_bytes(5*BPR + 1, 100);
    byte_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("bp_hold", 32'(byte_data), 32'(exp_byte(5, 1)));
      chk("bp_valid", 32'(byte_valid), 1);
    end
    @(posedge clk); #1;
    byte_ready = 1'b1;
    wait_done(400);
    repeat (2) @(posedge clk);
    #1;
    chk("bp_bytes", bytes_rx, NBYTES);
    chk("bp_done_cyc", done_cycle, DONE_CYC + 3);

    // abort while reg 10's 3rd byte transfers
    start_dump();
    wait_bytes(10*BPR + 2, 200);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_valid", 32'(byte_valid), 0);
    exp_q.delete();
    repeat (10) @(posedge clk);
    #1;
    chk("abort_no_done", done_cnt, 0);
    chk("abort_bytes", bytes_rx, 10*BPR + 3);

    // start pulsed again while busy
    start_dump();
    wait_cycle(50);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(400);
    repeat (20) @(posedge clk);
    #1;
    chk("rst2_done_cnt", done_cnt, 1);
    chk("rst2_bytes", bytes_rx, NBYTES);
    chk("rst2_done_cyc", done_cycle, DONE_CYC);
    chk("rst2_idle", 32'(busy), 0);

    // asynchronous reset mid-dump
    start_dump();
    wait_cycle(30);
    @(negedge clk);
    #2;
    chk("ar_pre_valid", 32'(byte_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(byte_valid), 0);
    chk("ar_busy", 32'(busy), 0);
    chk("ar_addr", 32'(reg_addr), 0);
    exp_q.delete();
    tracking = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    start_dump();
    wait_bytes(0, 10);
    chk("ar_byte0", 32'(byte_data), 32'(exp_byte(0, 0)));
    wait_done(400);
    repeat (2) @(posedge clk);
    #1;
    chk("ar_bytes", bytes_rx, NBYTES);
    chk("ar_done_cyc", done_cycle, DONE_CYC);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
